// File: rtl/mux16_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mux16_rr_arbiter_pkg
// Shared constants for the 16-lane round-robin arbiter and its interface:
//   N_LANES  number of requester lanes sharing the bit-select mux
//   SEL_W    width of the mux select / lane index
//   CNT_W    width of the per-grant transfer counter
//   ST_IDLE / ST_GRANT  1-bit arbiter state encodings
// ---------------------------------------------------------------------------
package mux16_rr_arbiter_pkg;

    localparam int N_LANES = 16;
    localparam int SEL_W   = 4;
    localparam int CNT_W   = 8;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

endpackage

// File: rtl/mux16_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// mux16_rr_arbiter_if
// Bundles the producer-lane and sink-side signals of the arbiter.
//   req/din      per-lane request and data bit (producers -> arbiter)
//   sel/gnt      registered mux select and one-hot grant (arbiter -> lanes)
//   dout         selected data bit to the sink
//   dout_valid   dout holds a transferable bit
//   dout_ready   sink accepts dout this cycle
//   busy         arbiter is in its GRANT state
// Modports: master = environment (producers + sink), slave = arbiter.
// ---------------------------------------------------------------------------
interface mux16_rr_arbiter_if;
    import mux16_rr_arbiter_pkg::*;

    logic [N_LANES-1:0] req;
    logic [N_LANES-1:0] din;
    logic [SEL_W-1:0]   sel;
    logic [N_LANES-1:0] gnt;
    logic               dout;
    logic               dout_valid;
    logic               dout_ready;
    logic               busy;

    modport master (
        output req, din, dout_ready,
        input  sel, gnt, dout, dout_valid, busy
    );

    modport slave (
        input  req, din, dout_ready,
        output sel, gnt, dout, dout_valid, busy
    );

endinterface

// File: rtl/mux16to1_v2.sv
// ---------------------------------------------------------------------------
// mux16to1_v2
// 16:1 single-bit select mux shared by the arbiter datapath.
//   in   16 candidate bits
//   sel  index of the bit to forward
//   out  in[sel], purely combinational
// ---------------------------------------------------------------------------
module mux16to1_v2 (
    input  logic [15:0] in,
    input  logic [3:0]  sel,
    output logic        out
);

    assign out = in[sel];

endmodule

// File: rtl/mux16_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux16_rr_arbiter
// Round-robin arbiter granting one of 16 lanes at a time onto the shared
// bit-select mux and streaming the granted lane's data bit to one sink over
// a valid/ready handshake. A grant lasts until the lane withdraws its request
// or HOLD_MAX transfers complete; priority then rotates past the lane.
// Parameters:
//   HOLD_MAX  transfers per grant before forced rotation (1..255)
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  mux16_rr_arbiter_if.slave (req, din, dout_ready in;
//        sel, gnt, dout, dout_valid, busy out)
// ---------------------------------------------------------------------------
module mux16_rr_arbiter
    import mux16_rr_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    mux16_rr_arbiter_if.slave     bus
);

    logic [0:0]         state_q, state_d;
    logic [SEL_W-1:0]   ptr_q,   ptr_d;
    logic [SEL_W-1:0]   sel_q,   sel_d;
    logic [N_LANES-1:0] gnt_q,   gnt_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    logic               dout_valid;
    logic               xfer;
    logic [SEL_W-1:0]   pick;

    // First requesting lane at or above p, wrapping 15 -> 0. Scanning the
    // offsets from highest to lowest lets the nearest hit overwrite the rest.
    function automatic logic [SEL_W-1:0] rr_pick(
        input logic [N_LANES-1:0] r,
        input logic [SEL_W-1:0]   p
    );
        logic [SEL_W-1:0] idx;
        rr_pick = p;
        for (int k = N_LANES - 1; k >= 0; k--) begin
            idx = p + SEL_W'(k);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    assign pick       = rr_pick(bus.req, ptr_q);
    assign dout_valid = (state_q == ST_GRANT) && bus.req[sel_q];
    assign xfer       = dout_valid && bus.dout_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        if (state_q == ST_IDLE) begin
            if (bus.req != '0) begin
                sel_d   = pick;
                gnt_d   = N_LANES'(1) << pick;
                cnt_d   = '0;
                state_d = ST_GRANT;
            end
        end else begin
            if (xfer) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            // Withdrawal or an exhausted budget both end the grant; sel keeps
            // its value so dout still reflects the last lane while idle.
            if (!bus.req[sel_q] || (xfer && cnt_q == CNT_W'(HOLD_MAX - 1))) begin
                state_d = ST_IDLE;
                ptr_d   = sel_q + SEL_W'(1);
                gnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
        end
    end

    mux16to1_v2 u_mux (
        .in  (bus.din),
        .sel (sel_q),
        .out (bus.dout)
    );

    assign bus.sel        = sel_q;
    assign bus.gnt        = gnt_q;
    assign bus.dout_valid = dout_valid;
    assign bus.busy       = (state_q == ST_GRANT);

endmodule
